// File: rtl/fetch_modrm_sib_parser_pkg.sv
// Shared types and encodings for the ModR/M/SIB operand parser.
// Combinational definitions only; no latency.
// No flow control here; see the parser and accumulator.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MODRM = 3'd1,
    SIB   = 3'd2,
    DISP  = 3'd3,
    IMM   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Register encodings that change addressing meaning
  localparam logic [3:0] RSP_ENC = 4'b0100;  // SIB index "none"
  localparam logic [2:0] RBP_LOW = 3'b101;   // disp32 / no-base forms
  localparam logic [2:0] SIB_RM  = 3'b100;   // rm value that pulls in a SIB byte

  // Legal immediate sizes in bytes
  localparam logic [3:0] IMM_SZ_0 = 4'd0;
  localparam logic [3:0] IMM_SZ_1 = 4'd1;
  localparam logic [3:0] IMM_SZ_2 = 4'd2;
  localparam logic [3:0] IMM_SZ_4 = 4'd4;
  localparam logic [3:0] IMM_SZ_8 = 4'd8;

  // Operand descriptor; wide fields are held at 64 bits and trimmed at the port
  typedef struct packed {
    logic [3:0]  reg_num;
    logic        rm_is_reg;
    logic [3:0]  base;
    logic [3:0]  index;
    logic        base_none;
    logic        index_none;
    logic [1:0]  scale;
    logic        rip_rel;
    logic [63:0] disp;
    logic [63:0] imm;
    logic        dst_rm;
    logic [63:0] pc;
    logic [3:0]  len;
    logic        err;
  } desc_t;

  function automatic logic imm_size_legal(input logic [3:0] sz);
    return (sz == IMM_SZ_0) || (sz == IMM_SZ_1) || (sz == IMM_SZ_2) ||
           (sz == IMM_SZ_4) || (sz == IMM_SZ_8);
  endfunction

endpackage

// File: rtl/fetch_modrm_sib_parser_if.sv
// Handshake bundle between opcode stage, byte fetch and micro-op generation.
// Wires only; no latency.
// Three independent valid/ready channels: start context, bytes, descriptor.
interface fetch_modrm_sib_parser_if #(parameter int ADDR_W = 64);
  logic              start_valid;
  logic              start_ready;
  logic [3:0]        start_rex;
  logic              start_dst_rm;
  logic [3:0]        start_imm_size;
  logic [ADDR_W-1:0] start_pc;
  logic              byte_valid;
  logic              byte_ready;
  logic [7:0]        byte_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_reg;
  logic              out_rm_is_reg;
  logic [3:0]        out_base;
  logic [3:0]        out_index;
  logic              out_base_none;
  logic              out_index_none;
  logic [1:0]        out_scale;
  logic              out_rip_rel;
  logic [ADDR_W-1:0] out_disp;
  logic [ADDR_W-1:0] out_imm;
  logic              out_dst_rm;
  logic [ADDR_W-1:0] out_pc;
  logic [3:0]        out_len;
  logic              out_err;

  // Upstream/downstream side (drives context and bytes, consumes descriptors)
  modport master (
    output start_valid, start_rex, start_dst_rm, start_imm_size, start_pc,
    output byte_valid, byte_data, out_ready,
    input  start_ready, byte_ready, out_valid, out_reg, out_rm_is_reg,
    input  out_base, out_index, out_base_none, out_index_none, out_scale,
    input  out_rip_rel, out_disp, out_imm, out_dst_rm, out_pc, out_len, out_err
  );

  // Parser side
  modport slave (
    input  start_valid, start_rex, start_dst_rm, start_imm_size, start_pc,
    input  byte_valid, byte_data, out_ready,
    output start_ready, byte_ready, out_valid, out_reg, out_rm_is_reg,
    output out_base, out_index, out_base_none, out_index_none, out_scale,
    output out_rip_rel, out_disp, out_imm, out_dst_rm, out_pc, out_len, out_err
  );
endinterface

// File: rtl/fetch_modrm_sib_parser_le_accum.sv
// Little-endian byte accumulator with target length and sign extension.
// val_o/last_o are combinational over the byte being accepted this cycle.
// No backpressure of its own; caller gates byte_vld_i with its handshake.
module fetch_le_accum (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_i,
  input  logic [3:0]  ld_len_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        last_o,
  output logic [63:0] val_o
);
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q;
  logic [3:0]  tgt_q;

  // Merge the incoming byte at its little-endian slot and sign-extend by length
  always_comb begin
    acc_d = acc_q;
    acc_d[{cnt_q[2:0], 3'b000} +: 8] = byte_dat_i;
    last_o = ((cnt_q + 4'd1) == tgt_q);
    case (tgt_q)
      4'd1:    val_o = {{56{acc_d[7]}}, acc_d[7:0]};
      4'd2:    val_o = {{48{acc_d[15]}}, acc_d[15:0]};
      4'd4:    val_o = {{32{acc_d[31]}}, acc_d[31:0]};
      default: val_o = acc_d;
    endcase
  end

  // Load restarts a field (wins over a byte the same cycle); bytes shift in otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      tgt_q <= '0;
    end else if (ld_i) begin
      acc_q <= '0;
      cnt_q <= '0;
      tgt_q <= ld_len_i;
    end else if (byte_vld_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule

// File: rtl/fetch_modrm_sib_parser.sv
// Sequential ModR/M, SIB, displacement and immediate parser, one byte per cycle.
// Descriptor valid on the edge after the final byte; N bytes take >= N+1 cycles.
// Holds DONE while out_ready is low; flush drops the parse and refuses inputs.
module fetch_modrm_sib_parser
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int RIP_REL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  fetch_modrm_sib_parser_if.slave  io
);
  state_e      state_q, state_d;
  desc_t       desc_q;
  logic [1:0]  mod_q;
  logic [3:0]  imm_sz_q;
  logic [2:0]  rex_q;        // {R, X, B}
  logic        start_fire, byte_fire;
  logic        acc_ld, acc_last, acc_byte;
  logic [3:0]  acc_len;
  logic [63:0] acc_val;
  logic        need_disp, tail;
  logic [3:0]  disp_len;
  logic [1:0]  b_mod;
  logic [2:0]  b_mid, b_low;

  assign b_mod = io.byte_data[7:6];
  assign b_mid = io.byte_data[5:3];
  assign b_low = io.byte_data[2:0];

  assign io.start_ready = !flush && (state_q == IDLE || (state_q == DONE && io.out_ready));
  assign io.byte_ready  = !flush && (state_q == MODRM || state_q == SIB ||
                                     state_q == DISP  || state_q == IMM);
  assign start_fire = io.start_valid && io.start_ready;
  assign byte_fire  = io.byte_valid && io.byte_ready;
  assign acc_byte   = byte_fire && (state_q == DISP || state_q == IMM);

  fetch_le_accum u_acc (
    .clk        (clk),
    .rst        (rst),
    .ld_i       (acc_ld),
    .ld_len_i   (acc_len),
    .byte_vld_i (acc_byte),
    .byte_dat_i (io.byte_data),
    .last_o     (acc_last),
    .val_o      (acc_val)
  );

  // Next state, plus loading the accumulator with the length of the field entered next
  always_comb begin
    state_d   = state_q;
    acc_ld    = 1'b0;
    acc_len   = 4'd0;
    need_disp = 1'b0;
    disp_len  = 4'd0;
    tail      = 1'b0;
    case (state_q)
      IDLE:  if (start_fire) state_d = MODRM;
      MODRM: if (byte_fire) begin
        if (b_mod == 2'b11)                            tail = 1'b1;
        else if (b_low == SIB_RM)                      state_d = SIB;
        else if (b_mod == 2'b01)                       begin need_disp = 1'b1; disp_len = 4'd1; end
        else if (b_mod == 2'b10 || b_low == RBP_LOW)   begin need_disp = 1'b1; disp_len = 4'd4; end
        else                                           tail = 1'b1;
      end
      SIB:   if (byte_fire) begin
        if (mod_q == 2'b01)                            begin need_disp = 1'b1; disp_len = 4'd1; end
        else if (mod_q == 2'b10 || b_low == RBP_LOW)   begin need_disp = 1'b1; disp_len = 4'd4; end
        else                                           tail = 1'b1;
      end
      DISP:  if (byte_fire && acc_last) tail = 1'b1;
      IMM:   if (byte_fire && acc_last) state_d = DONE;
      DONE:  if (io.out_ready) state_d = start_fire ? MODRM : IDLE;
      default: state_d = IDLE;
    endcase
    if (tail) begin
      if (imm_sz_q != IMM_SZ_0) begin
        state_d = IMM;
        acc_ld  = 1'b1;
        acc_len = imm_sz_q;
      end else begin
        state_d = DONE;
      end
    end
    if (need_disp) begin
      state_d = DISP;
      acc_ld  = 1'b1;
      acc_len = disp_len;
    end
    if (flush) begin
      state_d = IDLE;
      acc_ld  = 1'b0;
    end
  end

  // State register and descriptor assembly; fields default to "no SIB parsed"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      desc_q   <= '0;
      mod_q    <= '0;
      imm_sz_q <= '0;
      rex_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_fire) begin
        desc_q            <= '0;
        desc_q.index_none <= 1'b1;
        desc_q.dst_rm     <= io.start_dst_rm;
        desc_q.pc         <= 64'(io.start_pc);
        desc_q.err        <= !imm_size_legal(io.start_imm_size);
        imm_sz_q          <= imm_size_legal(io.start_imm_size) ? io.start_imm_size : IMM_SZ_0;
        rex_q             <= io.start_rex[2:0];
      end
      if (byte_fire) begin
        desc_q.len <= desc_q.len + 4'd1;
        case (state_q)
          MODRM: begin
            mod_q          <= b_mod;
            desc_q.reg_num <= {rex_q[2], b_mid};
            if (b_mod == 2'b11) begin
              desc_q.rm_is_reg <= 1'b1;
              desc_q.base      <= {rex_q[0], b_low};
            end else if (b_mod == 2'b00 && b_low == RBP_LOW) begin
              desc_q.base_none <= 1'b1;
              desc_q.rip_rel   <= (RIP_REL != 0);
            end else if (b_low != SIB_RM) begin
              desc_q.base <= {rex_q[0], b_low};
            end
          end
          SIB: begin
            desc_q.scale <= b_mod;
            if ({rex_q[1], b_mid} != RSP_ENC) begin
              desc_q.index_none <= 1'b0;
              desc_q.index      <= {rex_q[1], b_mid};
            end
            if (mod_q == 2'b00 && b_low == RBP_LOW) desc_q.base_none <= 1'b1;
            else                                    desc_q.base      <= {rex_q[0], b_low};
          end
          DISP: if (acc_last) desc_q.disp <= acc_val;
          IMM:  if (acc_last) desc_q.imm  <= acc_val;
          default: ;
        endcase
      end
    end
  end

  assign io.out_valid      = (state_q == DONE);
  assign io.out_reg        = desc_q.reg_num;
  assign io.out_rm_is_reg  = desc_q.rm_is_reg;
  assign io.out_base       = desc_q.base;
  assign io.out_index      = desc_q.index;
  assign io.out_base_none  = desc_q.base_none;
  assign io.out_index_none = desc_q.index_none;
  assign io.out_scale      = desc_q.scale;
  assign io.out_rip_rel    = desc_q.rip_rel;
  assign io.out_disp       = desc_q.disp[ADDR_W-1:0];
  assign io.out_imm        = desc_q.imm[ADDR_W-1:0];
  assign io.out_dst_rm     = desc_q.dst_rm;
  assign io.out_pc         = desc_q.pc[ADDR_W-1:0];
  assign io.out_len        = desc_q.len;
  assign io.out_err        = desc_q.err;
endmodule

// File: tb/tb_fetch_modrm_sib_parser.sv
// Directed bench for the ModR/M/SIB parser with an expected-descriptor queue.
// Expectations are pushed as each instruction starts and popped on out handshake.
// Covers reset, SIB/disp/imm forms, RIP-relative, flush, backpressure, illegal imm.
module tb_fetch_modrm_sib_parser;
  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fetch_modrm_sib_parser_if #(.ADDR_W(64)) io ();

  fetch_modrm_sib_parser #(.ADDR_W(64), .RIP_REL(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (io)
  );

  typedef struct packed {
    logic [3:0]  rg;
    logic        rmr;
    logic [3:0]  base;
    logic        bn;
    logic [3:0]  idx;
    logic        in_;
    logic [1:0]  sc;
    logic        rip;
    logic [63:0] disp;
    logic [63:0] imm;
    logic        dst;
    logic [63:0] pc;
    logic [3:0]  len;
    logic        err;
  } exp_t;

  exp_t  sb[$];
  string sb_name[$];
  exp_t  mon_e;
  string mon_n;
  int    compared = 0;
  int    mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    compared++;
    mismatched++;
    $error("FAIL timeout_%s: observed=no handshake expected=handshake within bound", tag);
  endtask

  function automatic exp_t mk(input logic [3:0] rg, input logic rmr, input logic [3:0] base,
                              input logic bn, input logic [3:0] idx, input logic in_,
                              input logic [1:0] sc, input logic rip, input logic [63:0] disp,
                              input logic [63:0] imm, input logic dst, input logic [63:0] pc,
                              input logic [3:0] len, input logic err);
    exp_t e;
    e.rg = rg; e.rmr = rmr; e.base = base; e.bn = bn; e.idx = idx; e.in_ = in_;
    e.sc = sc; e.rip = rip; e.disp = disp; e.imm = imm; e.dst = dst; e.pc = pc;
    e.len = len; e.err = err;
    return e;
  endfunction

  task automatic push(input string name, input exp_t e);
    sb.push_back(e);
    sb_name.push_back(name);
  endtask

  // Scoreboard: compare every descriptor actually handed downstream
  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL sb_unexpected: observed=out_valid expected=no descriptor");
      end else begin
        mon_e = sb.pop_front();
        mon_n = sb_name.pop_front();
        chk({mon_n, ".reg"},        64'(io.out_reg),        64'(mon_e.rg));
        chk({mon_n, ".rm_is_reg"},  64'(io.out_rm_is_reg),  64'(mon_e.rmr));
        chk({mon_n, ".base"},       64'(io.out_base),       64'(mon_e.base));
        chk({mon_n, ".base_none"},  64'(io.out_base_none),  64'(mon_e.bn));
        chk({mon_n, ".index"},      64'(io.out_index),      64'(mon_e.idx));
        chk({mon_n, ".index_none"}, 64'(io.out_index_none), 64'(mon_e.in_));
        chk({mon_n, ".scale"},      64'(io.out_scale),      64'(mon_e.sc));
        chk({mon_n, ".rip_rel"},    64'(io.out_rip_rel),    64'(mon_e.rip));
        chk({mon_n, ".disp"},       io.out_disp,            mon_e.disp);
        chk({mon_n, ".imm"},        io.out_imm,             mon_e.imm);
        chk({mon_n, ".dst_rm"},     64'(io.out_dst_rm),     64'(mon_e.dst));
        chk({mon_n, ".pc"},         io.out_pc,              mon_e.pc);
        chk({mon_n, ".len"},        64'(io.out_len),        64'(mon_e.len));
        chk({mon_n, ".err"},        64'(io.out_err),        64'(mon_e.err));
      end
    end
  end

  task automatic do_start(input logic [3:0] rex, input logic dst, input logic [3:0] isz,
                          input logic [63:0] pc);
    int n;
    n = 0;
    io.start_valid    = 1'b1;
    io.start_rex      = rex;
    io.start_dst_rm   = dst;
    io.start_imm_size = isz;
    io.start_pc       = pc;
    @(negedge clk);
    while (!io.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.start_ready) tmo("start");
    @(posedge clk);
    #1;
    io.start_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    io.byte_valid = 1'b1;
    io.byte_data  = b;
    @(negedge clk);
    while (!io.byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.byte_ready) tmo("byte");
    @(posedge clk);
    #1;
    io.byte_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!io.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!io.out_valid) tmo("out");
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    io.start_valid = 1'b0;
    io.start_rex = '0;
    io.start_dst_rm = 1'b0;
    io.start_imm_size = '0;
    io.start_pc = '0;
    io.byte_valid = 1'b0;
    io.byte_data = '0;
    io.out_ready = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.out_valid",      64'(io.out_valid), 64'd0);
    chk("rst.start_ready",    64'(io.start_ready), 64'd1);
    chk("rst.byte_ready",     64'(io.byte_ready), 64'd0);
    chk("rst.out_reg",        64'(io.out_reg), 64'd0);
    chk("rst.out_index_none", 64'(io.out_index_none), 64'd0);
    chk("rst.out_disp",       io.out_disp, 64'd0);
    chk("rst.out_len",        64'(io.out_len), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Register-direct with REX.B, one byte, valid one cycle after it
    push("t1", mk(4'd0, 1'b1, 4'd11, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 64'd0, 64'd0,
                  1'b1, 64'h1000, 4'd1, 1'b0));
    do_start(4'b0001, 1'b1, 4'd0, 64'h1000);
    chk("t1.byte_ready_after_start", 64'(io.byte_ready), 64'd1);
    chk("t1.no_early_valid", 64'(io.out_valid), 64'd0);
    send_byte(8'hC3);
    chk("t1.valid_latency", 64'(io.out_valid), 64'd1);
    wait_out();

    // SIB with disp8 negative
    push("t2", mk(4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0,
                  64'd0, 1'b0, 64'h2000, 4'd3, 1'b0));
    do_start(4'b0000, 1'b0, 4'd0, 64'h2000);
    send_byte(8'h44);
    send_byte(8'h88);
    send_byte(8'hF0);
    wait_out();

    // RIP-relative disp32 plus 4-byte immediate of all ones
    push("t3", mk(4'd0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 2'd0, 1'b1, 64'h0000_0000_1234_5678,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h3000, 4'd9, 1'b0));
    do_start(4'b0000, 1'b0, 4'd4, 64'h3000);
    send_byte(8'h05);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    wait_out();

    // SIB no-index/no-base disp32 (negative), REX.R, imm8, with byte bubbles
    push("t4", mk(4'd8, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 2'd0, 1'b0, 64'hFFFF_FFFF_8433_2211,
                  64'h7F, 1'b0, 64'h4000, 4'd7, 1'b0));
    do_start(4'b0100, 1'b0, 4'd1, 64'h4000);
    send_byte(8'h04);
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h25);
    send_byte(8'h11);
    @(posedge clk);
    #1;
    chk("t4.bubble_no_valid", 64'(io.out_valid), 64'd0);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h84);
    send_byte(8'h7F);
    wait_out();

    // Flush while disp32 is pending; offered byte must not be taken
    do_start(4'b0000, 1'b1, 4'd0, 64'h5000);
    send_byte(8'h80);
    io.byte_valid = 1'b1;
    io.byte_data  = 8'hAA;
    flush = 1'b1;
    @(negedge clk);
    chk("t5.byte_ready_in_flush", 64'(io.byte_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    io.byte_valid = 1'b0;
    @(negedge clk);
    chk("t5.out_valid_after_flush",   64'(io.out_valid), 64'd0);
    chk("t5.start_ready_after_flush", 64'(io.start_ready), 64'd1);
    chk("t5.byte_ready_after_flush",  64'(io.byte_ready), 64'd0);
    repeat (3) @(negedge clk);
    chk("t5.still_idle", 64'(io.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Clean parse after flush: register form with imm16 negative
    push("t5b", mk(4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 64'd0,
                   64'hFFFF_FFFF_FFFF_9234, 1'b0, 64'h5100, 4'd3, 1'b0));
    do_start(4'b1000, 1'b0, 4'd2, 64'h5100);
    send_byte(8'hD8);
    send_byte(8'h34);
    send_byte(8'h92);
    wait_out();

    // Illegal imm size held under backpressure, then back-to-back start
    io.out_ready = 1'b0;
    push("t6a", mk(4'd0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 2'd0, 1'b0, 64'd0, 64'd0,
                   1'b1, 64'h6000, 4'd1, 1'b1));
    do_start(4'b0000, 1'b1, 4'd3, 64'h6000);
    send_byte(8'hC1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6.hold_valid", 64'(io.out_valid), 64'd1);
      chk("t6.hold_base",  64'(io.out_base), 64'd1);
      chk("t6.hold_err",   64'(io.out_err), 64'd1);
      chk("t6.hold_imm",   io.out_imm, 64'd0);
      chk("t6.hold_start_ready", 64'(io.start_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    io.out_ready = 1'b1;
    push("t6b", mk(4'd1, 1'b0, 4'd0, 1'b1, 4'd12, 1'b0, 2'd2, 1'b0, 64'd1, 64'd0,
                   1'b0, 64'h6100, 4'd6, 1'b0));
    do_start(4'b0010, 1'b0, 4'd0, 64'h6100);
    chk("t6.b2b_byte_ready", 64'(io.byte_ready), 64'd1);
    chk("t6.b2b_valid_low",  64'(io.out_valid), 64'd0);
    send_byte(8'h0C);
    send_byte(8'hA5);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_out();

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
